// File: rtl/eg_pwrmnt_seq_if.sv
// Signal bundle between the power-monitor sequencer, the PWRMNT macro pins and fabric logic.
// slave = sequencer side, master = fabric/macro side.
interface eg_pwrmnt_seq_if;
  logic       en;
  logic       sel_req;
  logic       fail_clr;
  logic       mon_sel_pwr;
  logic       mon_pwr_mnt_pd;
  logic       mon_pwr_dwn_n;
  logic       pwr_ok;
  logic       pwr_fail;
  logic       busy;
  // Event handshake: evt_code is held stable while evt_valid=1, and the
  // transfer happens on the clock edge where evt_valid & evt_ready are both 1.
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_ovf;

  modport slave (
    input  en, sel_req, fail_clr, mon_pwr_dwn_n, evt_ready,
    output mon_sel_pwr, mon_pwr_mnt_pd, pwr_ok, pwr_fail, busy,
           evt_valid, evt_code, evt_ovf
  );

  modport master (
    output en, sel_req, fail_clr, mon_pwr_dwn_n, evt_ready,
    input  mon_sel_pwr, mon_pwr_mnt_pd, pwr_ok, pwr_fail, busy,
           evt_valid, evt_code, evt_ovf
  );
endinterface

// File: rtl/eg_pwrmnt_seq.sv
// Sequencer for one EG_PHY_PWRMNT monitor: power-up/switch settling, synchronised and
// debounced pwr_dwn_n verdict, single-entry fault/recover event buffer.
module eg_pwrmnt_seq #(
  parameter int SETTLE_CYC = 64,
  parameter int DEB_CYC    = 8,
  parameter int PD_CYC     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  eg_pwrmnt_seq_if.slave     bus,
  output logic [2:0]         o_dbg_state
);

  localparam int MAXP_A = (SETTLE_CYC > DEB_CYC) ? SETTLE_CYC : DEB_CYC;
  localparam int MAXP   = (MAXP_A > PD_CYC) ? MAXP_A : PD_CYC;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PD_LD     = CW'(PD_CYC - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MONITOR = 3'd2,
    ST_FAULT   = 3'd3,
    ST_SWITCH  = 3'd4
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx;
  logic [CW-1:0]   r_deb, w_deb_nx;
  logic            r_sync1, r_syn;
  logic            r_sel, w_sel_nx;
  logic            r_pd, r_ok, r_busy, r_fail, r_ovf;
  logic            r_evt_valid;
  logic [1:0]      r_evt_code;
  logic            w_sw_req, w_post_fault, w_post_rec, w_post, w_pop;
  logic [1:0]      w_post_code;

  // Raw pwr_dwn_n is asynchronous to clk; only r_syn is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_syn   <= 1'b1;
    end else begin
      r_sync1 <= bus.mon_pwr_dwn_n;
      r_syn   <= r_sync1;
    end
  end

  assign w_sw_req = (bus.sel_req != r_sel);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_deb_nx     = r_deb;
    w_sel_nx     = r_sel;
    w_post_fault = 1'b0;
    w_post_rec   = 1'b0;
    if (!bus.en) begin
      w_state_nx = ST_OFF;
      w_cnt_nx   = '0;
      w_deb_nx   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_sel_nx   = bus.sel_req;
          w_cnt_nx   = SETTLE_LD;
          w_deb_nx   = '0;
          w_state_nx = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_sw_req) begin
            w_state_nx = ST_SWITCH;
            w_cnt_nx   = PD_LD;
            w_deb_nx   = '0;
          end else if (r_cnt == '0) begin
            w_state_nx = ST_MONITOR;
            w_deb_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        ST_MONITOR: begin
          // A pending switch pre-empts a verdict completing on the same edge.
          if (w_sw_req) begin
            w_state_nx = ST_SWITCH;
            w_cnt_nx   = PD_LD;
            w_deb_nx   = '0;
          end else if (!r_syn) begin
            if (r_deb == DEB_LAST) begin
              w_state_nx   = ST_FAULT;
              w_deb_nx     = '0;
              w_post_fault = 1'b1;
            end else begin
              w_deb_nx = r_deb + 1'b1;
            end
          end else begin
            w_deb_nx = '0;
          end
        end
        ST_FAULT: begin
          if (w_sw_req) begin
            w_state_nx = ST_SWITCH;
            w_cnt_nx   = PD_LD;
            w_deb_nx   = '0;
          end else if (r_syn) begin
            if (r_deb == DEB_LAST) begin
              w_state_nx = ST_MONITOR;
              w_deb_nx   = '0;
              w_post_rec = 1'b1;
            end else begin
              w_deb_nx = r_deb + 1'b1;
            end
          end else begin
            w_deb_nx = '0;
          end
        end
        ST_SWITCH: begin
          if (r_cnt == '0) begin
            w_sel_nx   = bus.sel_req;
            w_cnt_nx   = SETTLE_LD;
            w_state_nx = ST_SETTLE;
          end else begin
            w_cnt_nx = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_OFF;
          w_cnt_nx   = '0;
          w_deb_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_deb   <= '0;
      r_sel   <= 1'b0;
      r_pd    <= 1'b1;
      r_ok    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_deb   <= w_deb_nx;
      r_sel   <= w_sel_nx;
      r_pd    <= (w_state_nx == ST_OFF) || (w_state_nx == ST_SWITCH);
      r_ok    <= (w_state_nx == ST_MONITOR);
      r_busy  <= (w_state_nx == ST_SETTLE) || (w_state_nx == ST_SWITCH);
    end
  end

  assign w_pop       = r_evt_valid & bus.evt_ready;
  assign w_post      = w_post_fault | w_post_rec;
  assign w_post_code = w_post_fault ? 2'b01 : 2'b10;

  // Event buffer and sticky flags ignore en; a set always beats fail_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= 2'b00;
      r_ovf       <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      if (w_post && (!r_evt_valid || w_pop)) begin
        r_evt_valid <= 1'b1;
        r_evt_code  <= w_post_code;
      end else if (w_pop) begin
        r_evt_valid <= 1'b0;
        r_evt_code  <= 2'b00;
      end

      if (w_post && r_evt_valid && !w_pop)
        r_ovf <= 1'b1;
      else if (bus.fail_clr)
        r_ovf <= 1'b0;

      if (w_post_fault)
        r_fail <= 1'b1;
      else if (bus.fail_clr)
        r_fail <= 1'b0;
    end
  end

  assign bus.mon_sel_pwr    = r_sel;
  assign bus.mon_pwr_mnt_pd = r_pd;
  assign bus.pwr_ok         = r_ok;
  assign bus.pwr_fail       = r_fail;
  assign bus.busy           = r_busy;
  assign bus.evt_valid      = r_evt_valid;
  assign bus.evt_code       = r_evt_code;
  assign bus.evt_ovf        = r_ovf;
  assign o_dbg_state        = r_state;

endmodule
